regfile_wb_arbiter: RTL and testbench

- Owns the single write port (A3/WD3/WE3) of the 32x32 register file and shares it between two requesters:
  - the core writeback path, which has priority;
  - a debug/loader write port, which uses a valid/ready handshake and has starvation protection.
- Also sequences a software-triggered clear of x1..x31 through the same port.
- Sits between the writeback stage and the register file; all outputs to the register file are registered.

---
 rtl/rv_rf_pkg.sv | 15 +
 rtl/rf_clear_seq.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 82 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_rf_pkg.sv
// Shared register-file constants and the write-port arbiter state encoding.
package rv_rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_LAST = 5'd31;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks x1..x31 once per start pulse, ignoring restarts while busy.
module rf_clear_seq (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic [rv_rf_pkg::ADDR_W-1:0] idx
);
  import rv_rf_pkg::*;

  rf_state_e state;
  logic      last;

  assign busy = (state == CLEAR);
  assign last = busy & (idx == REG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      idx   <= ADDR_W'(1);
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state <= CLEAR;
            idx   <= ADDR_W'(1);
          end
        end
        CLEAR: begin
          if (last) begin
            state <= RUN;
            idx   <= ADDR_W'(1);
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= RUN;
          idx   <= ADDR_W'(1);
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core writeback first, debug port with
// starvation forcing, and a sequenced clear of x1..x31; rf outputs registered.
module regfile_wb_arbiter #(
  parameter int DATA_W       = rv_rf_pkg::DATA_W,
  parameter int ADDR_W       = rv_rf_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_stall,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd
);
  import rv_rf_pkg::*;

  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] clr_idx;
  logic              force_dbg;
  logic              dbg_grant;
  logic              core_grant;

  rf_clear_seq u_clear_seq (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .busy  (clr_busy),
    .idx   (clr_idx)
  );

  // dbg_ready is gated by rst so it reads 0 while reset is held.
  always_comb begin
    force_dbg  = ~clr_busy & dbg_valid & (starve_cnt == 4'(STARVE_LIMIT));
    core_stall = clr_busy | force_dbg;
    dbg_ready  = rst & ~clr_busy & (force_dbg | ~core_we);
    dbg_grant  = dbg_valid & dbg_ready;
    core_grant = core_we & ~core_stall;
  end

  // Output register stage: one-cycle latency from grant to register-file port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd      <= '0;
      starve_cnt <= '0;
    end else if (clr_busy) begin
      rf_we <= 1'b1;
      rf_a3 <= clr_idx;
      rf_wd <= '0;
    end else begin
      if (dbg_grant) begin
        rf_we <= (dbg_addr != REG_ZERO);
        rf_a3 <= dbg_addr;
        rf_wd <= dbg_data;
      end else if (core_grant) begin
        rf_we <= (core_rd != REG_ZERO);
        rf_a3 <= core_rd;
        rf_wd <= core_wd;
      end else begin
        rf_we <= 1'b0;
      end

      // Any cycle debug waits behind the core counts as a lost arbitration.
      if (dbg_grant || !dbg_valid) begin
        starve_cnt <= '0;
      end else if (core_we && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed sequences, random vs. model.
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_wd = '0;
  logic        core_stall;
  logic        dbg_valid = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data = '0;
  logic        dbg_ready;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_rd(core_rd), .core_wd(core_wd), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cwe;
    logic [4:0]  crd;
    logic [31:0] cwd;
    logic        dv;
    logic [4:0]  da;
    logic [31:0] dd;
    logic        stall;
    logic        ready;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    core_we = 1'b0; core_rd = '0; core_wd = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
    clr_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // Reference model state, expressed in the terms of the arbitration rules.
  bit          m_clear;
  int          m_next;
  int          m_lost;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  initial begin
    bit core_hold, dbg_hold, frc, dacc, cacc, e_stall, e_ready;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000055, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00000055};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 5'd0,  32'h00000055};
    vecs[5] = '{1'b1, 5'd10, 32'h00000011, 1'b1, 5'd12, 32'h00000022, 1'b0, 1'b0, 1'b1, 5'd10, 32'h00000011};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h00000022, 1'b0, 1'b1, 1'b1, 5'd12, 32'h00000022};
    vecs[7] = '{1'b1, 5'd1,  32'hCAFEF00D, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd1,  32'hCAFEF00D};

    // Reset values while reset is held, with an idle core so dbg_ready gating is visible.
    idle();
    rst = 1'b0;
    #12;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_a3", rf_a3, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_ready", dbg_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      core_we = vecs[i].cwe; core_rd = vecs[i].crd; core_wd = vecs[i].cwd;
      dbg_valid = vecs[i].dv; dbg_addr = vecs[i].da; dbg_data = vecs[i].dd;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), core_stall, vecs[i].stall);
      chk($sformatf("vec%0d_ready", i), dbg_ready, vecs[i].ready);
      tick();
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
      chk($sformatf("vec%0d_a3", i), rf_a3, vecs[i].a3);
      chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].wd);
    end

    // Starvation: four lost cycles, then debug forced through
    core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h33;
    dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("starve_ready_low", dbg_ready, 0);
      chk("starve_stall_low", core_stall, 0);
      tick();
      chk("starve_core_a3", rf_a3, 3);
    end
    @(negedge clk);
    chk("force_stall", core_stall, 1);
    chk("force_ready", dbg_ready, 1);
    tick();
    chk("force_we", rf_we, 1);
    chk("force_a3", rf_a3, 7);
    chk("force_wd", rf_wd, 32'h1234);
    dbg_valid = 1'b0;
    @(negedge clk);
    chk("after_force_stall", core_stall, 0);
    tick();
    chk("after_force_core_a3", rf_a3, 3);
    chk("after_force_core_wd", rf_wd, 32'h33);
    dbg_valid = 1'b1;
    @(negedge clk);
    chk("starve_restart_ready", dbg_ready, 0);
    tick();
    chk("starve_restart_a3", rf_a3, 3);
    idle();
    tick();

    // Clear sequence with a core write in the start cycle and a restart attempt mid-way
    clr_start = 1'b1; core_we = 1'b1; core_rd = 5'd4; core_wd = 32'h44;
    @(negedge clk);
    chk("clr_start_busy0", clr_busy, 0);
    chk("clr_start_stall0", core_stall, 0);
    tick();
    chk("clr_start_core_a3", rf_a3, 4);
    idle();
    for (int i = 1; i <= 31; i++) begin
      clr_start = (i == 10);
      if (i == 5) begin
        core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h333;
        dbg_valid = 1'b1; dbg_addr = 5'd20; dbg_data = 32'h2020;
      end
      @(negedge clk);
      chk($sformatf("clr%0d_busy", i), clr_busy, 1);
      chk($sformatf("clr%0d_stall", i), core_stall, 1);
      chk($sformatf("clr%0d_ready", i), dbg_ready, 0);
      tick();
      chk($sformatf("clr%0d_we", i), rf_we, 1);
      chk($sformatf("clr%0d_a3", i), rf_a3, i);
      chk($sformatf("clr%0d_wd", i), rf_wd, 0);
    end
    clr_start = 1'b0;
    @(negedge clk);
    chk("clr_done_busy", clr_busy, 0);
    chk("clr_done_stall", core_stall, 0);
    chk("clr_done_ready", dbg_ready, 0);
    tick();
    chk("clr_stalled_core_we", rf_we, 1);
    chk("clr_stalled_core_a3", rf_a3, 3);
    chk("clr_stalled_core_wd", rf_wd, 32'h333);
    core_we = 1'b0;
    @(negedge clk);
    chk("clr_dbg_ready", dbg_ready, 1);
    tick();
    chk("clr_dbg_a3", rf_a3, 20);
    chk("clr_dbg_wd", rf_wd, 32'h2020);
    idle();
    tick();

    // Asynchronous reset in the middle of a clear
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("midclr_a3", rf_a3, i);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("midclr_rst_we", rf_we, 0);
    chk("midclr_rst_busy", clr_busy, 0);
    chk("midclr_rst_a3", rf_a3, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midclr_idle_busy", clr_busy, 0);
    core_we = 1'b1; core_rd = 5'd9; core_wd = 32'h99;
    @(negedge clk);
    chk("midclr_x9_stall", core_stall, 0);
    tick();
    chk("midclr_x9_we", rf_we, 1);
    chk("midclr_x9_a3", rf_a3, 9);
    chk("midclr_x9_wd", rf_wd, 32'h99);

    // Randomized traffic against the model
    do_reset();
    m_clear = 0; m_next = 1; m_lost = 0; m_we = 0; m_a3 = '0; m_wd = '0;
    core_hold = 0; dbg_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!core_hold) begin
        core_we = ($urandom_range(0, 2) != 0);
        core_rd = 5'($urandom);
        core_wd = $urandom;
      end
      if (!dbg_hold) begin
        dbg_valid = ($urandom_range(0, 1) == 1);
        dbg_addr  = 5'($urandom);
        dbg_data  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        dbg_valid = 1'b0;
      end
      clr_start = ($urandom_range(0, 59) == 0);

      if (m_clear) begin
        e_stall = 1; e_ready = 0;
      end else begin
        frc = (m_lost == LIMIT) && dbg_valid;
        e_stall = frc;
        e_ready = frc || !core_we;
      end
      @(negedge clk);
      chk("rnd_stall", core_stall, e_stall);
      chk("rnd_ready", dbg_ready, e_ready);
      chk("rnd_busy", clr_busy, m_clear);

      dacc = !m_clear && dbg_valid && e_ready;
      cacc = !m_clear && core_we && !e_stall;
      if (m_clear) begin
        m_we = 1; m_a3 = 5'(m_next); m_wd = '0;
        if (m_next == 31) begin m_clear = 0; m_next = 1; end
        else m_next++;
      end else begin
        if (dacc) begin m_we = (dbg_addr != 0); m_a3 = dbg_addr; m_wd = dbg_data; end
        else if (cacc) begin m_we = (core_rd != 0); m_a3 = core_rd; m_wd = core_wd; end
        else m_we = 0;
        if (dacc || !dbg_valid) m_lost = 0;
        else if (core_we && m_lost < 15) m_lost++;
        if (clr_start) begin m_clear = 1; m_next = 1; end
      end
      core_hold = core_we && !cacc;
      dbg_hold  = dbg_valid && !dacc;

      tick();
      chk("rnd_rf_we", rf_we, m_we);
      chk("rnd_rf_a3", rf_a3, m_a3);
      chk("rnd_rf_wd", rf_wd, m_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
